data_mem: RTL and testbench

Byte-addressed, little-endian data memory for the MEM stage of the 5-stage RV32I pipeline. It supports byte, halfword and word stores and loads selected by a 2-bit size code. Writes and reads are synchronous to the pipeline clock. Load results are zero-extended; sign extension for LB/LH is done downstream in the writeback/load-extend logic.

---
 rtl/dmem_pkg.sv | 26 ++
 rtl/dmem_lane_ctrl.sv | 34 +++
 rtl/data_mem.sv | 68 ++++++
 tb/tb_data_mem.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the MEM-stage data memory: size codes, store payload
// and the byte-lane enable function.
package dmem_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned LANES  = WORD_W / 8;

    localparam logic [1:0] SEL_BYTE = 2'b00;
    localparam logic [1:0] SEL_HALF = 2'b01;
    localparam logic [1:0] SEL_WORD = 2'b10;

    typedef struct packed {
        logic [LANES-1:0]  be;
        logic [WORD_W-1:0] data;
    } dmem_store_t;

    // Byte lanes touched by an access of size sel at byte offset lane; 2'b11 acts as word.
    function automatic logic [LANES-1:0] lane_mask(input logic [1:0] sel, input logic [1:0] lane);
        case (sel)
            SEL_BYTE: return 4'b0001 << lane;
            SEL_HALF: return lane[1] ? 4'b1100 : 4'b0011;
            default:  return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_ctrl.sv
// Combinational lane steering: store-side byte enables and replicated data,
// load-side alignment and zero extension.
module dmem_lane_ctrl
    import dmem_pkg::*;
(
    input  logic [1:0]        sel,
    input  logic [1:0]        lane,
    input  logic [WORD_W-1:0] store_data,
    input  logic [WORD_W-1:0] read_word,
    output dmem_store_t       store_c,
    output logic [WORD_W-1:0] load_data_c
);

    // Replicating the data across lanes lets the byte enables alone pick the target bytes.
    always_comb begin
        store_c      = '0;
        store_c.be   = lane_mask(sel, lane);
        case (sel)
            SEL_BYTE: store_c.data = {4{store_data[7:0]}};
            SEL_HALF: store_c.data = {2{store_data[15:0]}};
            default:  store_c.data = store_data;
        endcase
    end

    always_comb begin
        load_data_c = '0;
        case (sel)
            SEL_BYTE: load_data_c = WORD_W'(read_word[{lane, 3'b000} +: 8]);
            SEL_HALF: load_data_c = WORD_W'(read_word[{lane[1], 4'b0000} +: 16]);
            default:  load_data_c = read_word;
        endcase
    end

endmodule

// File: rtl/data_mem.sv
// Byte-addressed little-endian data memory with byte/half/word access,
// read-first on simultaneous access and a registered zero-extended load port.
module data_mem
    import dmem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned D_ADD_WIDTH = 5
) (
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic [DATA_WIDTH-1:0]  Mem_in,
    input  logic [D_ADD_WIDTH-1:0] Mem_addr,
    input  logic [1:0]             sel,
    input  logic                   write,
    input  logic                   read,
    output logic [DATA_WIDTH-1:0]  Mem_out
);

    localparam int unsigned IDX_W = D_ADD_WIDTH - 2;
    localparam int unsigned WORDS = 1 << IDX_W;

    logic [WORDS-1:0][WORD_W-1:0] mem;
    logic [IDX_W-1:0]             idx;
    logic [WORD_W-1:0]            cur_word;
    logic [WORD_W-1:0]            merged_c;
    logic [WORD_W-1:0]            load_data_c;
    dmem_store_t                  store_c;

    assign idx      = Mem_addr[D_ADD_WIDTH-1:2];
    assign cur_word = mem[idx];

    dmem_lane_ctrl u_lane_ctrl (
        .sel         (sel),
        .lane        (Mem_addr[1:0]),
        .store_data  (Mem_in),
        .read_word   (cur_word),
        .store_c     (store_c),
        .load_data_c (load_data_c)
    );

    // Byte-masked merge of store data into the addressed word.
    always_comb begin
        merged_c = cur_word;
        for (int b = 0; b < int'(LANES); b++) begin
            if (store_c.be[b]) begin
                merged_c[8*b +: 8] = store_c.data[8*b +: 8];
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            mem <= '0;
        end else if (write) begin
            mem[idx] <= merged_c;
        end
    end

    // Load samples pre-store contents, giving read-first behaviour.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            Mem_out <= '0;
        end else if (read) begin
            Mem_out <= load_data_c;
        end
    end

endmodule

// File: tb/tb_data_mem.sv
// Self-checking bench for data_mem against a byte-array reference model.
`timescale 1ns/1ps
module tb_data_mem;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [31:0] Mem_in;
    logic [4:0]  Mem_addr;
    logic [1:0]  sel;
    logic        write;
    logic        read;
    logic [31:0] Mem_out;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  ref_mem [32];
    logic [31:0] exp_out;

    data_mem dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .Mem_in   (Mem_in),
        .Mem_addr (Mem_addr),
        .sel      (sel),
        .write    (write),
        .read     (read),
        .Mem_out  (Mem_out)
    );

    always #5 Clk = ~Clk;

    function automatic int eff_addr(input int a, input logic [1:0] s);
        if (s == 2'b00) return a;
        if (s == 2'b01) return a & ~1;
        return a & ~3;
    endfunction

    function automatic int nbytes(input logic [1:0] s);
        if (s == 2'b00) return 1;
        if (s == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] model_read(input int a, input logic [1:0] s);
        logic [31:0] v;
        int ea;
        v  = 32'h0;
        ea = eff_addr(a, s);
        for (int k = 0; k < nbytes(s); k++) v[8*k +: 8] = ref_mem[ea + k];
        return v;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) ref_mem[i] = 8'h00;
        exp_out = 32'h0;
    endtask

    // One clock of stimulus; the model applies read-before-write at the edge.
    task automatic cycle(input logic [4:0] a, input logic [1:0] s, input logic wr,
                         input logic rd, input logic [31:0] din);
        int ea;
        @(negedge Clk);
        Mem_addr = a; sel = s; write = wr; read = rd; Mem_in = din;
        @(posedge Clk);
        if (rd) exp_out = model_read(int'(a), s);
        if (wr) begin
            ea = eff_addr(int'(a), s);
            for (int k = 0; k < nbytes(s); k++) ref_mem[ea + k] = din[8*k +: 8];
        end
        #1;
        write = 1'b0; read = 1'b0;
    endtask

    task automatic test_reset();
        Rst = 1'b0; Mem_in = 32'hFFFF_FFFF; Mem_addr = 5'd0; sel = 2'b10;
        write = 1'b0; read = 1'b0;
        model_clear();
        repeat (3) @(posedge Clk);
        #1;
        checks++;
        if (Mem_out !== 32'h0) begin
            failures++; $display("FAIL reset_out: got %h want %h", Mem_out, 32'h0);
        end
        @(negedge Clk); Rst = 1'b1;
        cycle(5'h00, 2'b10, 1'b0, 1'b1, 32'h0);
        checks++;
        if (Mem_out !== 32'h0) begin
            failures++; $display("FAIL reset_rd00: got %h want %h", Mem_out, 32'h0);
        end
        cycle(5'h1C, 2'b10, 1'b0, 1'b1, 32'h0);
        checks++;
        if (Mem_out !== 32'h0) begin
            failures++; $display("FAIL reset_rd1c: got %h want %h", Mem_out, 32'h0);
        end
    endtask

    task automatic test_word();
        cycle(5'h08, 2'b10, 1'b1, 1'b0, 32'hDEADBEEF);
        cycle(5'h08, 2'b10, 1'b0, 1'b1, 32'h0);
        checks++;
        if (Mem_out !== 32'hDEADBEEF) begin
            failures++; $display("FAIL word_rd08: got %h want %h", Mem_out, 32'hDEADBEEF);
        end
        cycle(5'h0B, 2'b10, 1'b0, 1'b1, 32'h0);
        checks++;
        if (Mem_out !== 32'hDEADBEEF) begin
            failures++; $display("FAIL word_rd0b: got %h want %h", Mem_out, 32'hDEADBEEF);
        end
        cycle(5'h09, 2'b11, 1'b0, 1'b1, 32'h0);
        checks++;
        if (Mem_out !== 32'hDEADBEEF) begin
            failures++; $display("FAIL word_sel11: got %h want %h", Mem_out, 32'hDEADBEEF);
        end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] want [4];
        want[0] = 32'hEF; want[1] = 32'hBE; want[2] = 32'hAD; want[3] = 32'hDE;
        for (int i = 0; i < 4; i++) begin
            cycle(5'(8 + i), 2'b00, 1'b0, 1'b1, 32'h0);
            checks++;
            if (Mem_out !== want[i]) begin
                failures++; $display("FAIL byte_rd lane%0d: got %h want %h", i, Mem_out, want[i]);
            end
        end
        cycle(5'h09, 2'b00, 1'b1, 1'b0, 32'hFFFF_FF55);
        cycle(5'h08, 2'b10, 1'b0, 1'b1, 32'h0);
        checks++;
        if (Mem_out !== 32'hDEAD55EF) begin
            failures++; $display("FAIL byte_wr09: got %h want %h", Mem_out, 32'hDEAD55EF);
        end
    endtask

    task automatic test_halfword();
        cycle(5'h0E, 2'b01, 1'b1, 1'b0, 32'h1234ABCD);
        cycle(5'h0E, 2'b00, 1'b0, 1'b1, 32'h0);
        checks++;
        if (Mem_out !== 32'hCD) begin
            failures++; $display("FAIL half_b0e: got %h want %h", Mem_out, 32'hCD);
        end
        cycle(5'h0F, 2'b00, 1'b0, 1'b1, 32'h0);
        checks++;
        if (Mem_out !== 32'hAB) begin
            failures++; $display("FAIL half_b0f: got %h want %h", Mem_out, 32'hAB);
        end
        cycle(5'h0F, 2'b01, 1'b0, 1'b1, 32'h0);
        checks++;
        if (Mem_out !== 32'h0000ABCD) begin
            failures++; $display("FAIL half_rd0f: got %h want %h", Mem_out, 32'h0000ABCD);
        end
        cycle(5'h0C, 2'b10, 1'b0, 1'b1, 32'h0);
        checks++;
        if (Mem_out !== 32'hABCD0000) begin
            failures++; $display("FAIL half_word0c: got %h want %h", Mem_out, 32'hABCD0000);
        end
    endtask

    task automatic test_simultaneous();
        cycle(5'h04, 2'b10, 1'b1, 1'b0, 32'h11111111);
        cycle(5'h04, 2'b10, 1'b1, 1'b1, 32'h22222222);
        checks++;
        if (Mem_out !== 32'h11111111) begin
            failures++; $display("FAIL simul_old: got %h want %h", Mem_out, 32'h11111111);
        end
        cycle(5'h04, 2'b10, 1'b0, 1'b1, 32'h0);
        checks++;
        if (Mem_out !== 32'h22222222) begin
            failures++; $display("FAIL simul_new: got %h want %h", Mem_out, 32'h22222222);
        end
    endtask

    task automatic test_hold();
        cycle(5'h04, 2'b10, 1'b1, 1'b0, 32'h33333333);
        checks++;
        if (Mem_out !== 32'h22222222) begin
            failures++; $display("FAIL hold_wr_same: got %h want %h", Mem_out, 32'h22222222);
        end
        cycle(5'h10, 2'b10, 1'b1, 1'b0, 32'h44444444);
        repeat (2) @(posedge Clk);
        #1;
        checks++;
        if (Mem_out !== 32'h22222222) begin
            failures++; $display("FAIL hold_idle: got %h want %h", Mem_out, 32'h22222222);
        end
    endtask

    task automatic test_random();
        logic [4:0]  a;
        logic [1:0]  s;
        logic        wr, rd;
        logic [31:0] d;
        for (int n = 0; n < 30; n++) begin
            a  = 5'($urandom_range(0, 31));
            s  = 2'($urandom_range(0, 3));
            wr = 1'($urandom_range(0, 1));
            rd = 1'($urandom_range(0, 1));
            d  = $urandom;
            cycle(a, s, wr, rd, d);
            checks++;
            if (Mem_out !== exp_out) begin
                failures++;
                $display("FAIL rand[%0d] a=%h s=%0d w=%0b r=%0b: got %h want %h",
                         n, a, s, wr, rd, Mem_out, exp_out);
            end
        end
        for (int w = 0; w < 8; w++) begin
            cycle(5'(4 * w), 2'b10, 1'b0, 1'b1, 32'h0);
            checks++;
            if (Mem_out !== exp_out) begin
                failures++; $display("FAIL sweep w%0d: got %h want %h", w, Mem_out, exp_out);
            end
        end
    endtask

    task automatic test_mid_reset();
        cycle(5'h18, 2'b10, 1'b1, 1'b0, 32'hA5A5A5A5);
        cycle(5'h18, 2'b10, 1'b0, 1'b1, 32'h0);
        checks++;
        if (Mem_out !== 32'hA5A5A5A5) begin
            failures++; $display("FAIL midrst_pre: got %h want %h", Mem_out, 32'hA5A5A5A5);
        end
        @(negedge Clk);
        #2 Rst = 1'b0;
        #1;
        checks++;
        if (Mem_out !== 32'h0) begin
            failures++; $display("FAIL midrst_async: got %h want %h", Mem_out, 32'h0);
        end
        model_clear();
        @(negedge Clk); Rst = 1'b1;
        for (int w = 0; w < 8; w++) begin
            cycle(5'(4 * w), 2'b10, 1'b0, 1'b1, 32'h0);
            checks++;
            if (Mem_out !== 32'h0) begin
                failures++; $display("FAIL midrst_clr w%0d: got %h want %h", w, Mem_out, 32'h0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte_lanes();
        test_halfword();
        test_simultaneous();
        test_hold();
        test_random();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
